// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and ALU control codes for the operand fetch stage and its register file.
package operand_fetch_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;
  localparam int IMM_W  = 16;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// 2-read / 1-write register file; register 0 is hardwired to zero, reads bypass the same-cycle write.
module reg_file
  import operand_fetch_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [AW-1:0] i_rd_addr_a,
  output logic [DW-1:0] o_rd_data_a,
  input  logic [AW-1:0] i_rd_addr_b,
  output logic [DW-1:0] o_rd_data_b
);

  logic [DW-1:0] regs [2**AW];
  logic          wb_hit;

  assign wb_hit = i_wb_en && (i_wb_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_rd_data_a = (wb_hit && (i_wb_addr == i_rd_addr_a)) ? i_wb_data :
                       (i_rd_addr_a == '0) ? '0 : regs[i_rd_addr_a];
  assign o_rd_data_b = (wb_hit && (i_wb_addr == i_rd_addr_b)) ? i_wb_data :
                       (i_rd_addr_b == '0) ? '0 : regs[i_rd_addr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads sources, extends the immediate, and holds ALU operands behind a valid/ready handshake.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
  parameter int REG_AW = operand_fetch_stage_pkg::REG_AW
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [REG_AW-1:0]        i_rs,
  input  logic [REG_AW-1:0]        i_rt,
  input  logic [IMM_W-1:0]         i_imm,
  input  logic                     i_use_imm,
  input  logic                     i_imm_zext,
  input  logic [CTRL_W-1:0]        i_control,
  input  logic                     i_wb_en,
  input  logic [REG_AW-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_op1,
  output logic signed [DATA_W-1:0] o_op2,
  output logic [CTRL_W-1:0]        o_control,
  output logic [DATA_W-1:0]        o_store_data
);

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm_ext;
  logic              load;

  reg_file #(.DW(DATA_W), .AW(REG_AW)) u_reg_file (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_rd_addr_a (i_rs),
    .o_rd_data_a (rs_data),
    .i_rd_addr_b (i_rt),
    .o_rd_data_b (rt_data)
  );

  assign imm_ext = i_imm_zext ? {{(DATA_W-IMM_W){1'b0}}, i_imm}
                              : {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

  // Ready depends only on our own state and downstream ready, never on i_valid.
  assign o_ready = !o_valid || i_ready;
  assign load    = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_op1        <= '0;
      o_op2        <= '0;
      o_control    <= '0;
      o_store_data <= '0;
    end else begin
      if (i_flush)      o_valid <= 1'b0;
      else if (load)    o_valid <= 1'b1;
      else if (i_ready) o_valid <= 1'b0;

      if (load) begin
        o_op1        <= rs_data;
        o_op2        <= i_use_imm ? imm_ext : rt_data;
        o_control    <= i_control;
        o_store_data <= rt_data;
      end
    end
  end

endmodule
